// File: rtl/int_sync_crossing_source_filt.sv
`default_nettype none
// ============================================================================
// Module   : int_sync_crossing_source_filt
// Purpose  : Registers WIDTH interrupt lines ahead of a synchronous crossing,
//            with an optional per-channel stability filter and per-channel
//            level or rising-edge-latched (software clear) behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module int_sync_crossing_source_filt #(
    parameter int               WIDTH         = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] EDGE_MASK     = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] auto_in,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] auto_out_sync
);

    logic [WIDTH-1:0] r_in_q;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_out_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_q <= '0;
        end else begin
            r_in_q <= auto_in;
        end
    end

    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            assign w_filt = r_in_q;
        end else begin : g_filt
            localparam logic [3:0] c_filter_cycles = 4'(FILTER_CYCLES);

            for (genvar i = 0; i < WIDTH; i++) begin : g_ch
                logic       r_filt;
                logic [3:0] r_cnt;

                // Any sample agreeing with the accepted value restarts the count.
                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_filt <= 1'b0;
                        r_cnt  <= 4'd0;
                    end else if (r_in_q[i] == r_filt) begin
                        r_cnt  <= 4'd0;
                    end else if (r_cnt + 4'd1 == c_filter_cycles) begin
                        r_filt <= r_in_q[i];
                        r_cnt  <= 4'd0;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end

                assign w_filt[i] = r_filt;
            end
        end
    endgenerate

    assign w_rise = w_filt & ~r_prev;

    // Edge channels: a new rise wins over a simultaneous clear.
    assign w_out_next = (EDGE_MASK & (w_rise | (r_out_q & ~clear)))
                      | (~EDGE_MASK & w_filt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev  <= '0;
            r_out_q <= '0;
        end else begin
            r_prev  <= w_filt;
            r_out_q <= w_out_next;
        end
    end

    assign auto_out_sync = r_out_q;

endmodule
`default_nettype wire

// File: tb/tb_int_sync_crossing_source_filt.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sync_crossing_source_filt
// Purpose  : Directed and randomised self-checking bench for the filtered
//            interrupt sync-crossing source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sync_crossing_source_filt;

    localparam int          c_nrand        = 3;
    localparam int          c_rf[c_nrand]  = '{0, 1, 15};
    localparam logic [31:0] c_rm0          = 32'hA5C3_961E;
    localparam logic [31:0] c_rm1          = 32'h0F0F_33CC;
    localparam logic [31:0] c_rm15         = 32'h5A5A_F00F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [1:0]  in_lvl = '0, clr_lvl = '0, out_lvl;
    logic [1:0]  in_edg = '0, clr_edg = '0, out_edg;
    logic [1:0]  in_f3  = '0, clr_f3  = '0, out_f3;
    logic [1:0]  in_f5  = '0, clr_f5  = '0, out_f5;
    logic [31:0] in_rnd = '0, clr_rnd = '0, out_r0, out_r1, out_r15;

    always #5 clk = ~clk;

    int_sync_crossing_source_filt #(.WIDTH(2), .FILTER_CYCLES(0), .EDGE_MASK(2'b00)) u_lvl (
        .clock(clk), .reset(rst), .auto_in(in_lvl), .clear(clr_lvl), .auto_out_sync(out_lvl));
    int_sync_crossing_source_filt #(.WIDTH(2), .FILTER_CYCLES(0), .EDGE_MASK(2'b10)) u_edg (
        .clock(clk), .reset(rst), .auto_in(in_edg), .clear(clr_edg), .auto_out_sync(out_edg));
    int_sync_crossing_source_filt #(.WIDTH(2), .FILTER_CYCLES(3), .EDGE_MASK(2'b00)) u_f3 (
        .clock(clk), .reset(rst), .auto_in(in_f3), .clear(clr_f3), .auto_out_sync(out_f3));
    int_sync_crossing_source_filt #(.WIDTH(2), .FILTER_CYCLES(5), .EDGE_MASK(2'b10)) u_f5 (
        .clock(clk), .reset(rst), .auto_in(in_f5), .clear(clr_f5), .auto_out_sync(out_f5));
    int_sync_crossing_source_filt #(.WIDTH(32), .FILTER_CYCLES(0), .EDGE_MASK(c_rm0)) u_r0 (
        .clock(clk), .reset(rst), .auto_in(in_rnd), .clear(clr_rnd), .auto_out_sync(out_r0));
    int_sync_crossing_source_filt #(.WIDTH(32), .FILTER_CYCLES(1), .EDGE_MASK(c_rm1)) u_r1 (
        .clock(clk), .reset(rst), .auto_in(in_rnd), .clear(clr_rnd), .auto_out_sync(out_r1));
    int_sync_crossing_source_filt #(.WIDTH(32), .FILTER_CYCLES(15), .EDGE_MASK(c_rm15)) u_r15 (
        .clock(clk), .reset(rst), .auto_in(in_rnd), .clear(clr_rnd), .auto_out_sync(out_r15));

    // Reference model: accepted value flips once the last F samples all disagree with it.
    logic [31:0] m_filt [c_nrand];
    logic [31:0] m_prev [c_nrand];
    logic [31:0] m_out  [c_nrand];
    logic [31:0] in_h   [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] c, input logic r);
        logic [31:0] nf, no, mask;
        logic        all_diff;
        for (int k = 0; k < c_nrand; k++) begin
            mask = (k == 0) ? c_rm0 : (k == 1) ? c_rm1 : c_rm15;
            if (r) begin
                m_filt[k] = '0;
                m_prev[k] = '0;
                m_out[k]  = '0;
            end else begin
                no = (~mask & m_filt[k])
                   | (mask & ((m_filt[k] & ~m_prev[k]) | (m_out[k] & ~c)));
                if (c_rf[k] == 0) begin
                    nf = a;
                end else begin
                    for (int b = 0; b < 32; b++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < c_rf[k]; j++)
                            if (in_h[j][b] == m_filt[k][b]) all_diff = 1'b0;
                        nf[b] = all_diff ? ~m_filt[k][b] : m_filt[k][b];
                    end
                end
                m_prev[k] = m_filt[k];
                m_filt[k] = nf;
                m_out[k]  = no;
            end
        end
        for (int j = 15; j > 0; j--) in_h[j] = r ? 32'h0 : in_h[j-1];
        in_h[0] = r ? 32'h0 : a;
    endtask

    task automatic test_reset;
        logic [31:0] got;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: got = {30'h0, out_lvl};
                1: got = {30'h0, out_edg};
                2: got = {30'h0, out_f3};
                3: got = {30'h0, out_f5};
                4: got = out_r0;
                5: got = out_r1;
                default: got = out_r15;
            endcase
            total++;
            if (got !== 32'h0) begin
                bad++;
                $display("FAIL reset_dut%0d got=%h exp=0", k, got);
            end
        end
    endtask

    task automatic test_level_basic;
        logic [1:0] exp_seq [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
        in_lvl = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (i == 1) in_lvl = 2'b00;
            total++;
            if (out_lvl !== exp_seq[i]) begin
                bad++;
                $display("FAIL level_basic step%0d got=%b exp=%b", i, out_lvl, exp_seq[i]);
            end
        end
    endtask

    task automatic test_filter;
        logic [1:0] exp_seq [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        in_f3 = 2'b01;
        tick;
        tick;
        in_f3 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick;
            total++;
            if (out_f3 !== 2'b00) begin
                bad++;
                $display("FAIL filter_glitch step%0d got=%b exp=00", i, out_f3);
            end
        end
        in_f3 = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i == 2) in_f3 = 2'b00;
            total++;
            if (out_f3 !== exp_seq[i]) begin
                bad++;
                $display("FAIL filter_pulse edge_k+%0d got=%b exp=%b", i, out_f3, exp_seq[i]);
            end
        end
    endtask

    task automatic test_edge;
        in_edg = 2'b01;
        tick;
        tick;
        in_edg = 2'b11;
        tick;
        in_edg = 2'b01;
        tick;
        total++;
        if (out_edg !== 2'b11) begin
            bad++;
            $display("FAIL edge_latch got=%b exp=11", out_edg);
        end
        for (int i = 0; i < 6; i++) begin
            clr_edg = {1'b0, i[0]};
            tick;
            total++;
            if (out_edg !== 2'b11) begin
                bad++;
                $display("FAIL edge_hold step%0d got=%b exp=11", i, out_edg);
            end
        end
        clr_edg = 2'b10;
        tick;
        clr_edg = 2'b00;
        total++;
        if (out_edg !== 2'b01) begin
            bad++;
            $display("FAIL edge_clear got=%b exp=01", out_edg);
        end
        tick;
        total++;
        if (out_edg !== 2'b01) begin
            bad++;
            $display("FAIL edge_clear_stays got=%b exp=01", out_edg);
        end
    endtask

    task automatic test_back_to_back;
        in_edg = 2'b11;
        tick;
        clr_edg = 2'b10;
        tick;
        clr_edg = 2'b00;
        total++;
        if (out_edg[1] !== 1'b1) begin
            bad++;
            $display("FAIL set_wins_clear got=%b exp=1", out_edg[1]);
        end
        in_edg = 2'b01;
        tick;
        tick;
        in_edg = 2'b11;
        tick;
        in_edg = 2'b01;
        tick;
        total++;
        if (out_edg[1] !== 1'b1) begin
            bad++;
            $display("FAIL second_rise got=%b exp=1", out_edg[1]);
        end
        clr_edg = 2'b10;
        tick;
        clr_edg = 2'b00;
        tick;
        total++;
        if (out_edg[1] !== 1'b0) begin
            bad++;
            $display("FAIL single_clear got=%b exp=0", out_edg[1]);
        end
    endtask

    task automatic test_reset_mid;
        in_f5 = 2'b10;
        for (int i = 0; i < 7; i++) tick;
        total++;
        if (out_f5 !== 2'b10) begin
            bad++;
            $display("FAIL f5_edge_latch got=%b exp=10", out_f5);
        end
        in_f5 = 2'b11;
        for (int i = 0; i < 4; i++) tick;
        total++;
        if (out_f5 !== 2'b10) begin
            bad++;
            $display("FAIL f5_mid_count got=%b exp=10", out_f5);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (out_f5 !== 2'b00) begin
            bad++;
            $display("FAIL f5_reset got=%b exp=00", out_f5);
        end
        for (int i = 1; i <= 7; i++) begin
            tick;
            total++;
            if (out_f5 !== ((i == 7) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL f5_release edge%0d got=%b exp=%b", i, out_f5,
                         (i == 7) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_random;
        logic        r_now;
        logic [31:0] got;
        rst = 1'b1;
        in_rnd = '0;
        clr_rnd = '0;
        tick;
        model_step(32'h0, 32'h0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            in_rnd  = in_rnd ^ ($urandom & $urandom & $urandom & $urandom);
            clr_rnd = $urandom & $urandom;
            r_now   = (i == 300) || (i == 301);
            rst     = r_now;
            tick;
            model_step(in_rnd, clr_rnd, r_now);
            rst = 1'b0;
            for (int k = 0; k < c_nrand; k++) begin
                got = (k == 0) ? out_r0 : (k == 1) ? out_r1 : out_r15;
                total++;
                if (got !== m_out[k]) begin
                    bad++;
                    $display("FAIL random_F%0d cycle%0d got=%h exp=%h", c_rf[k], i, got, m_out[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tick;
        tick;
        test_reset;
        rst = 1'b0;
        test_level_basic;
        test_filter;
        test_edge;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
